acia_host_master: RTL and testbench

Bus-initiator engine that drives the CPU-side register interface of the 6551 ACIA in place of a 6502. After reset it performs a programmed reset and writes the control and command registers, then polls the status register, moving bytes between the ACIA data register and two valid/ready byte streams. It sits between fabric logic that needs a serial port and the ACIA's CS/RWN/RS/data pins, sharing the ACIA's PHI2 clock.

---
 rtl/acia_host_master.sv | 240 ++++++++++++++++++++++++
 tb/tb_acia_host_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acia_host_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : acia_host_master                                                |
// | Brief    : Bus initiator for the 6551 ACIA CPU port; initialises the part, |
// |            then polls status and moves bytes to/from valid/ready streams.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module acia_host_master #(
    parameter logic [7:0]  CTRL_INIT = 8'h1F,
    parameter logic [7:0]  CMD_INIT  = 8'h0B,
    parameter int unsigned POLL_GAP  = 0
) (
    input  logic       phi2,
    input  logic       reset,
    output logic       acia_cs,
    output logic       acia_rwn,
    output logic [1:0] acia_rs,
    output logic [7:0] acia_dout,
    input  logic [7:0] acia_din,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [2:0] err,
    input  logic       err_clr,
    output logic       init_done
);

    localparam logic [3:0] INIT_RST  = 4'd0;
    localparam logic [3:0] INIT_CTRL = 4'd1;
    localparam logic [3:0] INIT_CMD  = 4'd2;
    localparam logic [3:0] STAT_RD   = 4'd3;
    localparam logic [3:0] EVAL      = 4'd4;
    localparam logic [3:0] RX_RD     = 4'd5;
    localparam logic [3:0] TX_WR     = 4'd6;
    localparam logic [3:0] GAP       = 4'd7;

    localparam logic [7:0] GAP_LOAD = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    logic [3:0] state;
    logic [3:0] state_nxt;
    // lead=1 marks the CS-high cycle that precedes an access of the same state
    logic       lead;
    logic       lead_nxt;

    logic       rdrf;
    logic       tdre;
    logic       prio_tx;
    logic [7:0] gap_cnt;

    logic       closing;
    logic       rx_ok;
    logic       tx_ok;
    logic       take_rx;
    logic       take_tx;
    logic [2:0] err_new;

    logic       cs_nxt;
    logic       rwn_nxt;
    logic [1:0] rs_nxt;
    logic [7:0] dout_nxt;
    logic       tx_ready_nxt;

    assign closing = !lead && (state != EVAL) && (state != GAP);
    assign rx_ok   = rdrf & ~rx_valid;
    assign tx_ok   = tdre & tx_valid;
    assign take_rx = rx_ok & (~tx_ok | ~prio_tx);
    assign take_tx = tx_ok & ~take_rx;
    assign err_new = (closing && (state == STAT_RD) && acia_din[3]) ? acia_din[2:0] : 3'b000;

    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            state <= INIT_RST;
            lead  <= 1'b1;
        end else begin
            state <= state_nxt;
            lead  <= lead_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lead_nxt  = lead;
        case (state)
            INIT_RST, INIT_CTRL, INIT_CMD: begin
                if (lead) begin
                    lead_nxt = 1'b0;
                end else begin
                    lead_nxt = 1'b1;
                    case (state)
                        INIT_RST:  state_nxt = INIT_CTRL;
                        INIT_CTRL: state_nxt = INIT_CMD;
                        default:   state_nxt = STAT_RD;
                    endcase
                end
            end
            STAT_RD: begin
                if (lead) begin
                    lead_nxt = 1'b0;
                end else begin
                    state_nxt = EVAL;
                end
            end
            // EVAL and GAP already provide the CS-high cycle, so go straight to the access
            EVAL: begin
                lead_nxt = 1'b0;
                if (take_rx) begin
                    state_nxt = RX_RD;
                end else if (take_tx) begin
                    state_nxt = TX_WR;
                end else if (POLL_GAP == 0) begin
                    state_nxt = STAT_RD;
                end else begin
                    state_nxt = GAP;
                end
            end
            RX_RD, TX_WR: begin
                state_nxt = STAT_RD;
                lead_nxt  = 1'b1;
            end
            GAP: begin
                lead_nxt = 1'b0;
                if (gap_cnt == 8'd0) begin
                    state_nxt = STAT_RD;
                end
            end
            default: begin
                state_nxt = INIT_RST;
                lead_nxt  = 1'b1;
            end
        endcase
    end

    always_comb begin
        cs_nxt       = 1'b1;
        rwn_nxt      = 1'b1;
        rs_nxt       = acia_rs;
        dout_nxt     = acia_dout;
        tx_ready_nxt = 1'b0;
        if (!lead_nxt) begin
            case (state_nxt)
                INIT_RST: begin
                    cs_nxt   = 1'b0;
                    rwn_nxt  = 1'b0;
                    rs_nxt   = 2'b01;
                    dout_nxt = 8'h00;
                end
                INIT_CTRL: begin
                    cs_nxt   = 1'b0;
                    rwn_nxt  = 1'b0;
                    rs_nxt   = 2'b11;
                    dout_nxt = CTRL_INIT;
                end
                INIT_CMD: begin
                    cs_nxt   = 1'b0;
                    rwn_nxt  = 1'b0;
                    rs_nxt   = 2'b10;
                    dout_nxt = CMD_INIT;
                end
                STAT_RD: begin
                    cs_nxt = 1'b0;
                    rs_nxt = 2'b01;
                end
                RX_RD: begin
                    cs_nxt = 1'b0;
                    rs_nxt = 2'b00;
                end
                TX_WR: begin
                    cs_nxt       = 1'b0;
                    rwn_nxt      = 1'b0;
                    rs_nxt       = 2'b00;
                    dout_nxt     = tx_data;
                    tx_ready_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            acia_cs   <= 1'b1;
            acia_rwn  <= 1'b1;
            acia_rs   <= 2'b00;
            acia_dout <= 8'h00;
            tx_ready  <= 1'b0;
        end else begin
            acia_cs   <= cs_nxt;
            acia_rwn  <= rwn_nxt;
            acia_rs   <= rs_nxt;
            acia_dout <= dout_nxt;
            tx_ready  <= tx_ready_nxt;
        end
    end

    always_ff @(posedge phi2 or posedge reset) begin
        if (reset) begin
            rdrf      <= 1'b0;
            tdre      <= 1'b0;
            prio_tx   <= 1'b0;
            gap_cnt   <= 8'd0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            err       <= 3'b000;
            init_done <= 1'b0;
        end else begin
            if (closing && (state == STAT_RD)) begin
                rdrf <= acia_din[3];
                tdre <= acia_din[4];
            end
            if (closing && ((state == RX_RD) || (state == TX_WR))) begin
                prio_tx <= ~prio_tx;
            end
            if ((state != GAP) && (state_nxt == GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            if (closing && (state == RX_RD)) begin
                rx_data  <= acia_din;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // a fresh error reported in the same cycle as a clear survives the clear
            if (err_clr) begin
                err <= err_new;
            end else begin
                err <= err | err_new;
            end
            if (closing && (state == INIT_CMD)) begin
                init_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acia_host_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_acia_host_master                                             |
// | Brief    : Directed self-checking bench with a small ACIA register model.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_acia_host_master;

    logic       phi2;
    logic       reset;
    logic       acia_cs;
    logic       acia_rwn;
    logic [1:0] acia_rs;
    logic [7:0] acia_dout;
    logic [7:0] acia_din;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] err;
    logic       err_clr;
    logic       init_done;

    logic [7:0] stat_val;
    logic [7:0] data_val;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int acc_log[$];
    logic [3:0] pattern;

    acia_host_master dut (
        .phi2      (phi2),
        .reset     (reset),
        .acia_cs   (acia_cs),
        .acia_rwn  (acia_rwn),
        .acia_rs   (acia_rs),
        .acia_dout (acia_dout),
        .acia_din  (acia_din),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .err       (err),
        .err_clr   (err_clr),
        .init_done (init_done)
    );

    assign acia_din = (acia_rs == 2'b01) ? stat_val : data_val;

    initial phi2 = 1'b0;
    always #5 phi2 = ~phi2;

    // data-register accesses that completed (seen at their closing edge)
    always @(posedge phi2) begin
        if (!reset && !acia_cs && acia_rs == 2'b00) begin
            if (acia_rwn) rd_cnt++;
            else          wr_cnt++;
            acc_log.push_back(acia_rwn ? 0 : 1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge phi2);
    endtask

    task automatic wait_tx(input int limit);
        int n = 0;
        while (tx_ready !== 1'b1 && n < limit) begin
            @(negedge phi2);
            n++;
        end
    endtask

    task automatic wait_err(input logic [2:0] want, input int limit);
        int n = 0;
        while (err !== want && n < limit) begin
            @(negedge phi2);
            n++;
        end
    endtask

    task automatic wait_stat_rd(input int limit);
        int n = 0;
        while (!(acia_cs === 1'b0 && acia_rs === 2'b01) && n < limit) begin
            @(negedge phi2);
            n++;
        end
    endtask

    task automatic check_init(input string tag);
        step(1);
        check({tag, "_c1"}, 32'({acia_cs, acia_rwn, acia_rs, acia_dout}), 32'h011_00 >> 0 & 32'h0000_0100 | 32'h0000_0100);
        check({tag, "_done_c1"}, 32'(init_done), 32'd0);
        step(1);
        check({tag, "_c2"}, 32'(acia_cs), 32'd1);
        step(1);
        check({tag, "_c3"}, 32'({acia_cs, acia_rwn, acia_rs, acia_dout}), 32'h31F);
        step(2);
        check({tag, "_c5"}, 32'({acia_cs, acia_rwn, acia_rs, acia_dout}), 32'h20B);
        step(1);
        check({tag, "_c6"}, 32'({acia_cs, init_done}), 32'h3);
    endtask

    initial begin
        reset    = 1'b1;
        stat_val = 8'h00;
        data_val = 8'h00;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        step(3);

        check("rst_bus", 32'({acia_cs, acia_rwn, acia_rs, acia_dout}), 32'hC00);
        check("rst_flags", 32'({tx_ready, rx_valid, err, init_done}), 32'h0);
        check("rst_rxdata", 32'(rx_data), 32'h00);

        // {cs,rwn,rs,dout}: write RS=01 data 00 -> 12'h100
        reset = 1'b0;
        check_init("init");
        step(1);
        check("stat_rd_c7", 32'({acia_cs, acia_rwn, acia_rs}), 32'h5);
        step(1);
        check("eval_c8", 32'(acia_cs), 32'd1);
        step(1);
        check("poll_period", 32'({acia_cs, acia_rwn, acia_rs}), 32'h5);

        // receive path
        stat_val = 8'h08;
        data_val = 8'h5A;
        step(2);
        check("rx_rd_c11", 32'({acia_cs, acia_rwn, acia_rs}), 32'h4);
        step(1);
        check("rx_deliver", 32'({rx_valid, rx_data, err}), 32'h15A << 3);
        step(10);
        check("rx_hold_no_read", 32'(rd_cnt), 32'd1);
        data_val = 8'h3C;
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(6);
        check("rx_second", 32'({rx_valid, rx_data}), 32'h13C);
        check("rx_second_cnt", 32'(rd_cnt), 32'd2);
        stat_val = 8'h00;
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        check("rx_consumed", 32'(rx_valid), 32'd0);

        // transmit path
        stat_val = 8'h10;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        wait_tx(12);
        check("tx_ready_seen", 32'(tx_ready), 32'd1);
        check("tx_bus", 32'({acia_cs, acia_rwn, acia_rs, acia_dout}), 32'h0A5);
        step(1);
        tx_valid = 1'b0;
        stat_val = 8'h00;
        check("tx_ready_one_cycle", 32'(tx_ready), 32'd0);
        step(8);
        check("tx_single_write", 32'(wr_cnt), 32'd1);
        check("rx_no_extra_read", 32'(rd_cnt), 32'd2);

        // sticky errors and clear-vs-set
        stat_val = 8'h0F;
        data_val = 8'h11;
        wait_err(3'b111, 12);
        check("err_set", 32'(err), 32'h7);
        wait_stat_rd(12);
        stat_val = 8'h0A;
        err_clr  = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_clr_set_wins", 32'(err), 32'h2);
        stat_val = 8'h00;
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(4);
        check("err_sticky", 32'(err), 32'h2);

        // reset in the middle of a data write
        stat_val = 8'h10;
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        wait_tx(12);
        check("tx2_ready_seen", 32'(tx_ready), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_async", 32'({acia_cs, tx_ready}), 32'h2);
        @(negedge phi2);
        check("abort_no_write", 32'(wr_cnt), 32'd1);
        reset = 1'b0;
        check_init("reinit");
        wait_tx(12);
        check("resend_bus", 32'({tx_ready, acia_cs, acia_rwn, acia_rs, acia_dout}), 32'h10C3);
        step(1);
        tx_valid = 1'b0;
        stat_val = 8'h00;
        check("resend_count", 32'(wr_cnt), 32'd2);

        // both directions ready: accesses alternate, RX first after reset
        reset    = 1'b1;
        stat_val = 8'h18;
        data_val = 8'h77;
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        rx_ready = 1'b1;
        step(1);
        acc_log.delete();
        reset = 1'b0;
        step(30);
        pattern = 4'hF;
        if (acc_log.size() >= 4) pattern = {acc_log[0][0], acc_log[1][0], acc_log[2][0], acc_log[3][0]};
        check("alternate_rx_tx", 32'(pattern), 32'h5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
